// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, memory-wait
// freezes, branch redirects with wrong-path fetch dropping, halt, and a stall counter.
module hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_wsel,
    input  logic             exm_memop,
    input  logic             exm_branch_taken,
    input  logic             mwb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exm_en,
    output logic             exm_flush,
    output logic             mwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             flush_pend_r;
    logic             flush_pend_next_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             load_use_s;
    logic             mem_stall_s;

    // A zero destination never forwards anything, so it can never create a hazard.
    assign load_use_s  = idex_memread && (idex_wsel != 5'd0) &&
                         ((idex_wsel == ifid_rs) || (ifid_uses_rt && (idex_wsel == ifid_rt)));
    assign mem_stall_s = exm_memop && !dhit;
    assign stall_cnt   = stall_cnt_r;

    // State register: control state and pending wrong-path fetch flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r      <= RUN;
            flush_pend_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            flush_pend_r <= flush_pend_next_s;
        end
    end

    // Next-state logic: a memory freeze defers halt and any flush_pend change.
    always_comb begin
        state_next_s      = state_r;
        flush_pend_next_s = flush_pend_r;
        case (state_r)
            RUN, MEMWAIT: begin
                if (mem_stall_s) begin
                    state_next_s = MEMWAIT;
                end else begin
                    if (mwb_halt) begin
                        state_next_s = HALTED;
                    end else begin
                        state_next_s = RUN;
                    end
                    // A redirect that completes its fetch discards it via ifid_flush directly.
                    if (exm_branch_taken) begin
                        flush_pend_next_s = !ihit;
                    end else if (flush_pend_r && ihit) begin
                        flush_pend_next_s = 1'b0;
                    end else begin
                        flush_pend_next_s = flush_pend_r;
                    end
                end
            end
            HALTED: begin
                state_next_s = HALTED;
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // Output logic: prioritised enable/flush decode from state and hazards.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exm_en     = 1'b0;
        exm_flush  = 1'b0;
        mwb_en     = 1'b0;
        halted     = 1'b0;
        case (state_r)
            HALTED: begin
                halted = 1'b1;
            end
            RUN, MEMWAIT: begin
                if (mem_stall_s) begin
                    halted = 1'b0;
                end else if (exm_branch_taken) begin
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    exm_flush  = 1'b1;
                    mwb_en     = 1'b1;
                end else if (load_use_s) begin
                    idex_flush = 1'b1;
                    exm_en     = 1'b1;
                    mwb_en     = 1'b1;
                    ifid_flush = flush_pend_r && ihit;
                end else if (!ihit) begin
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exm_en     = 1'b1;
                    mwb_en     = 1'b1;
                end else begin
                    // The first fetch after a missed redirect is wrong-path and is dropped.
                    pc_en      = 1'b1;
                    ifid_en    = !flush_pend_r;
                    ifid_flush = flush_pend_r;
                    idex_en    = 1'b1;
                    exm_en     = 1'b1;
                    mwb_en     = 1'b1;
                end
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    // Saturating count of non-halted cycles in which the PC is held.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r != HALTED) && !pc_en && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a reference model pushes expected controls to a
// scoreboard queue as each step is driven, popped and checked once outputs settle.
module tb_hazard_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, ifid_uses_rt, idex_memread, exm_memop, exm_branch_taken, mwb_halt;
    logic [4:0]  ifid_rs, ifid_rt, idex_wsel;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exm_en, exm_flush, mwb_en, halted;
    logic [31:0] stall_cnt;
    logic        pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4, exm_en4, exm_flush4, mwb_en4, halted4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_q[$];
    string       tag_q[$];

    // model state: 0 RUN, 1 MEMWAIT, 2 HALTED
    int          m_state;
    logic        m_fp;
    logic [31:0] m_cnt;

    hazard_unit dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_memread(idex_memread), .idex_wsel(idex_wsel),
        .exm_memop(exm_memop), .exm_branch_taken(exm_branch_taken), .mwb_halt(mwb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exm_en(exm_en), .exm_flush(exm_flush), .mwb_en(mwb_en),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    hazard_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .idex_memread(idex_memread), .idex_wsel(idex_wsel),
        .exm_memop(exm_memop), .exm_branch_taken(exm_branch_taken), .mwb_halt(mwb_halt),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_en(idex_en4),
        .idex_flush(idex_flush4), .exm_en(exm_en4), .exm_flush(exm_flush4), .mwb_en(mwb_en4),
        .halted(halted4), .stall_cnt(stall_cnt4)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic defaults();
        ihit = 1'b1; dhit = 1'b1; ifid_rs = 5'd1; ifid_rt = 5'd2; ifid_uses_rt = 1'b0;
        idex_memread = 1'b0; idex_wsel = 5'd0; exm_memop = 1'b0; exm_branch_taken = 1'b0;
        mwb_halt = 1'b0;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_fp    = 1'b0;
        m_cnt   = 32'd0;
    endtask

    // bits: pc_en ifid_en ifid_flush idex_en idex_flush exm_en exm_flush mwb_en halted
    function automatic logic [8:0] model_out();
        logic lu, ms;
        lu = idex_memread && (idex_wsel != 5'd0) &&
             ((idex_wsel == ifid_rs) || (ifid_uses_rt && (idex_wsel == ifid_rt)));
        ms = exm_memop && !dhit;
        if (m_state == 2)          return 9'b000000001;
        else if (ms)               return 9'b000000000;
        else if (exm_branch_taken) return 9'b101010110;
        else if (lu)               return 9'b000011010 | ((m_fp && ihit) ? 9'b001000000 : 9'b000000000);
        else if (!ihit)            return 9'b001101010;
        else if (m_fp)             return 9'b101101010;
        else                       return 9'b110101010;
    endfunction

    task automatic model_clock(input logic [8:0] e);
        logic ms;
        ms = exm_memop && !dhit;
        if (m_state != 2 && !e[8] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (m_state != 2 && !ms) begin
            if (exm_branch_taken)  m_fp = !ihit;
            else if (m_fp && ihit) m_fp = 1'b0;
        end
        if (m_state == 2)   m_state = 2;
        else if (ms)        m_state = 1;
        else if (mwb_halt)  m_state = 2;
        else                m_state = 0;
    endtask

    // Inputs must already be driven just after a falling edge.
    task automatic step(input string tag);
        logic [8:0] e, got, obs;
        string      t;
        e = model_out();
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        got = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exm_en, exm_flush, mwb_en, halted};
        checks++;
        assert (obs === got) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, obs, got);
        end
        model_clock(got);
        @(posedge CLK);
        #1;
        check_val({t, "_cnt"}, stall_cnt, m_cnt);
        check_val({t, "_cnt4"}, {28'd0, stall_cnt4}, (m_cnt > 32'd15) ? 32'd15 : m_cnt);
    endtask

    initial begin
        defaults();
        model_reset();
        nRST = 1'b0;
        #12;
        check_val("reset_cnt", stall_cnt, 32'd0);
        check_val("reset_halted", {31'd0, halted}, 32'd0);
        check_val("reset_pc_en", {31'd0, pc_en}, 32'd1);
        @(negedge CLK); nRST = 1'b1;
        step("idle");

        // load-use: one bubble then normal
        @(negedge CLK); idex_memread = 1'b1; idex_wsel = 5'd3; ifid_rs = 5'd3;
        step("lu_bubble");
        @(negedge CLK); defaults();
        step("lu_after");
        check_val("lu_cnt_one", stall_cnt, 32'd1);

        // D-miss for four cycles then hit
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); exm_memop = 1'b1; dhit = 1'b0;
            step("dmiss_freeze");
        end
        @(negedge CLK); dhit = 1'b1;
        step("dmiss_release");
        check_val("dmiss_cnt", stall_cnt, 32'd5);

        // redirect under I-miss, wrong-path fetch dropped
        @(negedge CLK); defaults(); exm_branch_taken = 1'b1; ihit = 1'b0;
        step("redir_imiss");
        @(negedge CLK); exm_branch_taken = 1'b0;
        step("redir_wait");
        @(negedge CLK); ihit = 1'b1;
        step("redir_drop");
        @(negedge CLK);
        step("redir_normal");

        // priority: branch over load-use, freeze over both
        @(negedge CLK); exm_branch_taken = 1'b1; idex_memread = 1'b1; idex_wsel = 5'd7; ifid_rs = 5'd7;
        step("prio_br_lu");
        @(negedge CLK); exm_memop = 1'b1; dhit = 1'b0;
        step("prio_freeze");
        @(negedge CLK); dhit = 1'b1;
        step("prio_reeval");

        // rt / zero-register gating
        @(negedge CLK); defaults(); idex_memread = 1'b1; idex_wsel = 5'd0; ifid_rs = 5'd0;
        step("gate_r0");
        @(negedge CLK); idex_wsel = 5'd5; ifid_rt = 5'd5; ifid_rs = 5'd1; ifid_uses_rt = 1'b0;
        step("gate_rt_unused");
        @(negedge CLK); ifid_uses_rt = 1'b1;
        step("gate_rt_used");

        // saturation of the narrow counter
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK); defaults(); ihit = 1'b0;
            step("sat_imiss");
        end
        check_val("sat_cnt4", {28'd0, stall_cnt4}, 32'd15);

        // halt deferred by a freeze, then taken
        @(negedge CLK); defaults(); mwb_halt = 1'b1; exm_memop = 1'b1; dhit = 1'b0;
        step("halt_deferred");
        @(negedge CLK); dhit = 1'b1;
        step("halt_take");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); defaults(); ihit = 1'b0;
            step("halted_hold");
        end
        check_val("halted_flag", {31'd0, halted}, 32'd1);

        // asynchronous reset out of HALTED
        @(negedge CLK); defaults(); nRST = 1'b0;
        #2;
        model_reset();
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        check_val("rst_cnt", stall_cnt, 32'd0);
        check_val("rst_cnt4", {28'd0, stall_cnt4}, 32'd0);
        @(negedge CLK); nRST = 1'b1;
        step("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
